dm_port_arbiter: RTL

DM_PORT_ARBITER -- requirements
Module: dm_port_arbiter

---
 rtl/dm_port_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/dm_port_arbiter.sv
// Data-memory port arbiter: shares one DM port between single-word core
// accesses and a DMA burst engine, with core priority bounded by a
// starvation limit that forces a DMA grant.
module dm_port_arbiter #(
    parameter int DMA_SIZE     = 17,
    parameter int DMD_SIZE     = 16,
    parameter int LEN_SIZE     = 8,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    // core side
    input  logic                core_dm_req,
    input  logic                core_dm_wrb,
    input  logic [DMA_SIZE-1:0] core_dm_add,
    input  logic [DMD_SIZE-1:0] core_dm_wdt,
    output logic                core_dm_stall,
    output logic                core_dm_rvalid,
    output logic [DMD_SIZE-1:0] core_dm_rdt,
    // DMA side
    input  logic                dma_start,
    input  logic                dma_wrb,
    input  logic [DMA_SIZE-1:0] dma_add,
    input  logic [LEN_SIZE-1:0] dma_len,
    input  logic                dma_wdt_valid,
    input  logic [DMD_SIZE-1:0] dma_wdt,
    output logic                dma_wdt_ready,
    output logic                dma_rvalid,
    output logic [DMD_SIZE-1:0] dma_rdt,
    output logic                dma_busy,
    output logic                dma_done,
    // DM port
    output logic                ps_dm_cslt,
    output logic                ps_dm_wrb,
    output logic [DMA_SIZE-1:0] dg_dm_add,
    output logic [DMD_SIZE-1:0] bc_dt,
    input  logic [DMD_SIZE-1:0] dm_bc_dt
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t              state_q, state_d;
    logic                burst_wrb_q, burst_wrb_d;
    logic [DMA_SIZE-1:0] burst_add_q, burst_add_d;
    logic [LEN_SIZE-1:0] rem_q, rem_d;
    logic [SW-1:0]       starve_q, starve_d;
    logic [DMA_SIZE-1:0] add_q, add_d;
    logic [DMD_SIZE-1:0] bc_dt_q, bc_dt_d;
    logic                rd_core_q, rd_core_d;
    logic                rd_dma_q, rd_dma_d;
    logic [DMD_SIZE-1:0] core_rdt_q, core_rdt_d;
    logic [DMD_SIZE-1:0] dma_rdt_q, dma_rdt_d;
    logic                done_q, done_d;

    logic dma_want, core_gnt, dma_gnt, start_ok, last_gnt;

    // Per-cycle arbitration; grants are suppressed while reset is high
    always_comb begin
        dma_want = (state_q == S_RUN) && (!burst_wrb_q || dma_wdt_valid);
        core_gnt = !reset && core_dm_req && !(dma_want && starve_q == STARVE_MAX);
        dma_gnt  = !reset && dma_want && !core_gnt;
        // DRAIN is the dma_done cycle, so a new command is accepted there too
        start_ok = dma_start && (dma_len != '0) &&
                   (state_q == S_IDLE || state_q == S_DRAIN);
        last_gnt = dma_gnt && (rem_q == LEN_SIZE'(1));
    end

    // Burst FSM state register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Burst FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_ok) state_d = S_RUN;
            S_RUN:   if (last_gnt) state_d = burst_wrb_q ? S_IDLE : S_DRAIN;
            S_DRAIN: state_d = start_ok ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Burst FSM outputs
    always_comb begin
        dma_busy = (state_q != S_IDLE);
    end

    // DM port command, write data and read-return routing
    always_comb begin
        ps_dm_cslt    = core_gnt || dma_gnt;
        ps_dm_wrb     = core_gnt ? core_dm_wrb : (dma_gnt ? burst_wrb_q : 1'b0);
        dg_dm_add     = core_gnt ? core_dm_add : (dma_gnt ? burst_add_q : add_q);
        core_dm_stall = core_dm_req && !core_gnt && !reset;
        dma_wdt_ready = dma_gnt && burst_wrb_q;
        bc_dt         = bc_dt_q;
        dma_done      = done_q;
        core_dm_rvalid = rd_core_q;
        core_dm_rdt    = rd_core_q ? dm_bc_dt : core_rdt_q;
        dma_rvalid     = rd_dma_q;
        dma_rdt        = rd_dma_q ? dm_bc_dt : dma_rdt_q;
    end

    // Next values for burst counters, starvation counter and port pipeline
    always_comb begin
        burst_wrb_d = burst_wrb_q;
        burst_add_d = burst_add_q;
        rem_d       = rem_q;
        if (start_ok) begin
            burst_wrb_d = dma_wrb;
            burst_add_d = dma_add;
            rem_d       = dma_len;
        end else if (dma_gnt) begin
            burst_add_d = burst_add_q + DMA_SIZE'(1);
            rem_d       = rem_q - LEN_SIZE'(1);
        end

        starve_d = starve_q;
        if (state_q != S_RUN || dma_gnt)
            starve_d = '0;
        else if (dma_want && starve_q != STARVE_MAX)
            starve_d = starve_q + SW'(1);

        add_d   = dg_dm_add;
        bc_dt_d = bc_dt_q;
        if (core_gnt && core_dm_wrb)
            bc_dt_d = core_dm_wdt;
        else if (dma_gnt && burst_wrb_q)
            bc_dt_d = dma_wdt;

        rd_core_d  = core_gnt && !core_dm_wrb;
        rd_dma_d   = dma_gnt && !burst_wrb_q;
        core_rdt_d = core_dm_rdt;
        dma_rdt_d  = dma_rdt;
        done_d     = last_gnt;
    end

    // Datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            burst_wrb_q <= 1'b0;
            burst_add_q <= '0;
            rem_q       <= '0;
            starve_q    <= '0;
            add_q       <= '0;
            bc_dt_q     <= '0;
            rd_core_q   <= 1'b0;
            rd_dma_q    <= 1'b0;
            core_rdt_q  <= '0;
            dma_rdt_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            burst_wrb_q <= burst_wrb_d;
            burst_add_q <= burst_add_d;
            rem_q       <= rem_d;
            starve_q    <= starve_d;
            add_q       <= add_d;
            bc_dt_q     <= bc_dt_d;
            rd_core_q   <= rd_core_d;
            rd_dma_q    <= rd_dma_d;
            core_rdt_q  <= core_rdt_d;
            dma_rdt_q   <= dma_rdt_d;
            done_q      <= done_d;
        end
    end

endmodule
